// File: rtl/reg_file_pkg.sv
// Shared types and constants for the multi-port integer register file.
package reg_file_pkg;

  // Source select for write port A.
  typedef enum logic [1:0] {
    WA_ALU   = 2'd0,
    WA_LINK  = 2'd1,
    WA_UPPER = 2'd2,
    WA_RSVD  = 2'd3
  } wa_sel_e;

  // Architectural zero register: reads 0, never written, never busy.
  localparam int unsigned REG_ZERO = '0;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy tracking for in-flight loads, plus a registered count
// of busy registers. A lock in the same cycle as a clear of the same
// register wins, so the register stays busy.
module rf_scoreboard
  import reg_file_pkg::*;
#(
  parameter int NREG = 32,
  parameter int AW   = $clog2(NREG)
) (
  input  logic            clk_i,
  input  logic            regrst_i,
  input  logic            lock_en_i,
  input  logic [AW-1:0]   lock_addr_i,
  input  logic            clr_en_i,
  input  logic [AW-1:0]   clr_addr_i,
  output logic [NREG-1:0] busy_o,
  output logic [AW:0]     busy_cnt_o
);

  localparam int CW = AW + 1;
  localparam logic [AW-1:0] ZERO_ADDR = AW'(REG_ZERO);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic            lock_ok;
  logic            clr_ok;
  logic            clr_same;
  logic            cnt_inc;
  logic            cnt_dec;

  assign lock_ok  = lock_en_i && (lock_addr_i != ZERO_ADDR);
  assign clr_ok   = clr_en_i && (clr_addr_i != ZERO_ADDR);
  assign clr_same = lock_ok && clr_ok && (lock_addr_i == clr_addr_i);
  // The counter only moves on a real transition of a busy bit.
  assign cnt_inc  = lock_ok && !busy_q[lock_addr_i];
  assign cnt_dec  = clr_ok && busy_q[clr_addr_i] && !clr_same;

  // Next busy vector: apply the clear first so a same-address lock overrides it.
  always_comb begin
    busy_d = busy_q;
    if (clr_ok) begin
      busy_d[clr_addr_i] = 1'b0;
    end
    if (lock_ok) begin
      busy_d[lock_addr_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Busy vector and counter registers; reset discards all pending loads.
  always_ff @(posedge clk_i) begin
    if (regrst_i) begin
      busy_q     <= '0;
      busy_cnt_o <= '0;
    end else begin
      busy_q <= busy_d;
      unique case ({cnt_inc, cnt_dec})
        2'b10:   busy_cnt_o <= busy_cnt_o + CW'(1);
        2'b01:   busy_cnt_o <= busy_cnt_o - CW'(1);
        default: busy_cnt_o <= busy_cnt_o;
      endcase
    end
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port integer register file with an ALU/link/upper write port, a
// late load write port, a load scoreboard and optional write-to-read bypass.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int NRD    = 2,
  parameter int BYPASS = 1
) (
  input  logic                      clk_i,
  input  logic                      regrst_i,
  input  logic [NRD*$clog2(NREG)-1:0] rs_i,
  output logic [NRD*XLEN-1:0]       rdata_o,
  output logic [NRD-1:0]            rbusy_o,
  input  logic                      wa_en_i,
  input  logic [$clog2(NREG)-1:0]   wa_addr_i,
  input  logic [1:0]                wa_sel_i,
  input  logic [XLEN-1:0]           wa_alu_i,
  input  logic [XLEN-1:0]           wa_link_i,
  input  logic [XLEN-1:0]           wa_upper_i,
  input  logic                      wb_en_i,
  input  logic [$clog2(NREG)-1:0]   wb_addr_i,
  input  logic [XLEN-1:0]           wb_data_i,
  input  logic                      lock_en_i,
  input  logic [$clog2(NREG)-1:0]   lock_addr_i,
  output logic [$clog2(NREG):0]     busy_cnt_o
);

  localparam int AW = $clog2(NREG);
  localparam logic [AW-1:0] ZERO_ADDR = AW'(REG_ZERO);

  logic [XLEN-1:0] regs_q [NREG];
  logic [NREG-1:0] busy;
  wa_sel_e         wa_sel;
  logic [XLEN-1:0] wa_data;
  logic            wa_ok;
  logic            wb_ok;
  logic            lock_ok;

  assign wa_sel  = wa_sel_e'(wa_sel_i);
  assign wa_ok   = wa_en_i && (wa_sel != WA_RSVD) && (wa_addr_i != ZERO_ADDR);
  assign wb_ok   = wb_en_i && (wb_addr_i != ZERO_ADDR);
  assign lock_ok = lock_en_i && (lock_addr_i != ZERO_ADDR);

  // Port A source mux; the reserved encoding is masked off in wa_ok.
  always_comb begin
    wa_data = wa_alu_i;
    unique case (wa_sel)
      WA_ALU:   wa_data = wa_alu_i;
      WA_LINK:  wa_data = wa_link_i;
      WA_UPPER: wa_data = wa_upper_i;
      default:  wa_data = wa_alu_i;
    endcase
  end

  // Storage array; port A is written last so the younger instruction wins a collision.
  always_ff @(posedge clk_i) begin
    if (regrst_i) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      if (wb_ok) begin
        regs_q[wb_addr_i] <= wb_data_i;
      end
      if (wa_ok) begin
        regs_q[wa_addr_i] <= wa_data;
      end
    end
  end

  rf_scoreboard #(
    .NREG (NREG),
    .AW   (AW)
  ) u_scoreboard (
    .clk_i       (clk_i),
    .regrst_i    (regrst_i),
    .lock_en_i   (lock_en_i),
    .lock_addr_i (lock_addr_i),
    .clr_en_i    (wb_en_i),
    .clr_addr_i  (wb_addr_i),
    .busy_o      (busy),
    .busy_cnt_o  (busy_cnt_o)
  );

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
    logic            rbusy;

    assign addr = rs_i[p*AW +: AW];

    // Read port: storage plus optional forwarding of this cycle's writes (A over B).
    always_comb begin
      data  = regs_q[addr];
      rbusy = busy[addr];
      if (BYPASS != 0) begin
        if (wb_ok && (wb_addr_i == addr)) begin
          data = wb_data_i;
          if (!(lock_ok && (lock_addr_i == addr))) begin
            rbusy = 1'b0;
          end
        end
        if (wa_ok && (wa_addr_i == addr)) begin
          data = wa_data;
        end
      end
      if (addr == ZERO_ADDR) begin
        data  = '0;
        rbusy = 1'b0;
      end
    end

    assign rdata_o[p*XLEN +: XLEN] = data;
    assign rbusy_o[p]              = rbusy;
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp (BYPASS=1, two read ports): a driver
// pushes expected read results from a behavioural model, a monitor pops
// and compares them each cycle; directed steps also check fixed values.
module tb_reg_file_mp;
  import reg_file_pkg::*;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int AW   = 5;

  logic              clk = 1'b0;
  logic              regrst;
  logic [NRD*AW-1:0] rs;
  logic [NRD*XLEN-1:0] rdata;
  logic [NRD-1:0]    rbusy;
  logic              wa_en;
  logic [AW-1:0]     wa_addr;
  logic [1:0]        wa_sel;
  logic [XLEN-1:0]   wa_alu, wa_link, wa_upper;
  logic              wb_en;
  logic [AW-1:0]     wb_addr;
  logic [XLEN-1:0]   wb_data;
  logic              lock_en;
  logic [AW-1:0]     lock_addr;
  logic [AW:0]       busy_cnt;

  typedef struct {
    logic [AW-1:0]   rs0, rs1;
    logic            wa_en;
    logic [AW-1:0]   wa_addr;
    logic [1:0]      wa_sel;
    logic [XLEN-1:0] alu, link, upper;
    logic            wb_en;
    logic [AW-1:0]   wb_addr;
    logic [XLEN-1:0] wb_data;
    logic            lock_en;
    logic [AW-1:0]   lock_addr;
    logic            rst;
  } stim_t;

  typedef struct {
    logic [XLEN-1:0] d0, d1;
    logic            b0, b1;
    logic [AW:0]     cnt;
  } exp_t;

  exp_t            exp_q[$];
  int              checks = 0;
  int              errors = 0;
  logic [XLEN-1:0] m_reg [NREG];
  bit              m_busy [NREG];

  always #5 clk = ~clk;

  reg_file_mp #(
    .XLEN   (XLEN),
    .NREG   (NREG),
    .NRD    (NRD),
    .BYPASS (1)
  ) dut (
    .clk_i       (clk),
    .regrst_i    (regrst),
    .rs_i        (rs),
    .rdata_o     (rdata),
    .rbusy_o     (rbusy),
    .wa_en_i     (wa_en),
    .wa_addr_i   (wa_addr),
    .wa_sel_i    (wa_sel),
    .wa_alu_i    (wa_alu),
    .wa_link_i   (wa_link),
    .wa_upper_i  (wa_upper),
    .wb_en_i     (wb_en),
    .wb_addr_i   (wb_addr),
    .wb_data_i   (wb_data),
    .lock_en_i   (lock_en),
    .lock_addr_i (lock_addr),
    .busy_cnt_o  (busy_cnt)
  );

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  // Value port A would write this cycle, and whether it writes at all.
  function automatic bit waActive();
    return wa_en && (wa_sel != 2'd3) && (wa_addr != 0);
  endfunction

  function automatic logic [XLEN-1:0] waValue();
    case (wa_sel)
      2'd1:    return wa_link;
      2'd2:    return wa_upper;
      default: return wa_alu;
    endcase
  endfunction

  // What an architectural read of register a should return right now.
  function automatic void modelRead(input logic [AW-1:0] a, output logic [XLEN-1:0] d,
                                    output logic b);
    if (a == 0) begin
      d = '0;
      b = 1'b0;
    end else begin
      d = m_reg[a];
      b = m_busy[a];
      if (wb_en && wb_addr == a) begin
        d = wb_data;
        if (!(lock_en && lock_addr == a)) b = 1'b0;
      end
      if (waActive() && wa_addr == a) d = waValue();
    end
  endfunction

  function automatic logic [AW:0] popBusy();
    int n = 0;
    for (int i = 0; i < NREG; i++) n += int'(m_busy[i]);
    return (AW+1)'(n);
  endfunction

  // Architectural state update at each clock edge.
  always @(posedge clk) begin
    if (regrst) begin
      for (int i = 0; i < NREG; i++) begin
        m_reg[i]  = '0;
        m_busy[i] = 1'b0;
      end
    end else begin
      if (wb_en && wb_addr != 0) begin
        m_reg[wb_addr]  = wb_data;
        m_busy[wb_addr] = 1'b0;
      end
      if (waActive()) m_reg[wa_addr] = waValue();
      if (lock_en && lock_addr != 0) m_busy[lock_addr] = 1'b1;
    end
  end

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    checkValue("rdata0", rdata[31:0], e.d0);
    checkValue("rdata1", rdata[63:32], e.d1);
    checkValue("rbusy0", 32'(rbusy[0]), 32'(e.b0));
    checkValue("rbusy1", 32'(rbusy[1]), 32'(e.b1));
    checkValue("busy_cnt", 32'(busy_cnt), 32'(e.cnt));
  endtask

  task automatic applyStimulus(input stim_t s);
    exp_t e;
    @(negedge clk);
    rs        = {s.rs1, s.rs0};
    wa_en     = s.wa_en;
    wa_addr   = s.wa_addr;
    wa_sel    = s.wa_sel;
    wa_alu    = s.alu;
    wa_link   = s.link;
    wa_upper  = s.upper;
    wb_en     = s.wb_en;
    wb_addr   = s.wb_addr;
    wb_data   = s.wb_data;
    lock_en   = s.lock_en;
    lock_addr = s.lock_addr;
    regrst    = s.rst;
    #1;
    modelRead(s.rs0, e.d0, e.b0);
    modelRead(s.rs1, e.d1, e.b1);
    e.cnt = popBusy();
    exp_q.push_back(e);
  endtask

  // Monitor: compare every queued expectation once the inputs have settled.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    stim_t s;
    regrst = 1'b1;
    rs = '0; wa_en = 0; wa_addr = '0; wa_sel = '0; wa_alu = '0; wa_link = '0;
    wa_upper = '0; wb_en = 0; wb_addr = '0; wb_data = '0; lock_en = 0; lock_addr = '0;
    for (int i = 0; i < NREG; i++) begin
      m_reg[i] = '0;
      m_busy[i] = 1'b0;
    end
    repeat (2) @(posedge clk);

    // All registers read zero and idle after reset.
    for (int k = 0; k < NREG / 2; k++) begin
      s = idle(); s.rs0 = AW'(2*k); s.rs1 = AW'(2*k+1);
      applyStimulus(s); #2;
      checkValue("rst_rdata0", rdata[31:0], 32'h0);
      checkValue("rst_rdata1", rdata[63:32], 32'h0);
      checkValue("rst_rbusy", 32'(rbusy), 32'h0);
      checkValue("rst_cnt", 32'(busy_cnt), 32'h0);
    end

    // Port A link select, and writes to x0 ignored.
    s = idle(); s.wa_en = 1; s.wa_addr = 5; s.wa_sel = WA_LINK;
    s.link = 32'h0000_1004; s.alu = 32'hDEAD_BEEF; applyStimulus(s);
    s = idle(); s.rs0 = 5; applyStimulus(s); #2;
    checkValue("x5_link", rdata[31:0], 32'h0000_1004);
    s = idle(); s.wa_en = 1; s.wa_addr = 0; s.wa_sel = WA_ALU; s.alu = 32'hFFFF_FFFF;
    applyStimulus(s); #2;
    checkValue("x0_bypass", rdata[31:0], 32'h0);
    s = idle(); applyStimulus(s); #2;
    checkValue("x0_read", rdata[31:0], 32'h0);

    // Lock x7, load writeback two cycles later.
    s = idle(); s.lock_en = 1; s.lock_addr = 7; s.rs0 = 7; applyStimulus(s);
    s = idle(); s.rs0 = 7; applyStimulus(s); #2;
    checkValue("x7_busy1", 32'(rbusy[0]), 32'h1);
    checkValue("x7_cnt1", 32'(busy_cnt), 32'h1);
    s = idle(); s.rs0 = 7; applyStimulus(s); #2;
    checkValue("x7_busy2", 32'(rbusy[0]), 32'h1);
    s = idle(); s.rs0 = 7; s.wb_en = 1; s.wb_addr = 7; s.wb_data = 32'hA5; applyStimulus(s); #2;
    checkValue("x7_bypass", rdata[31:0], 32'hA5);
    checkValue("x7_bypass_busy", 32'(rbusy[0]), 32'h0);
    s = idle(); s.rs0 = 7; applyStimulus(s); #2;
    checkValue("x7_data", rdata[31:0], 32'hA5);
    checkValue("x7_cnt0", 32'(busy_cnt), 32'h0);

    // A and B collide on busy x3.
    s = idle(); s.lock_en = 1; s.lock_addr = 3; applyStimulus(s);
    s = idle(); s.rs0 = 3; s.wa_en = 1; s.wa_addr = 3; s.wa_sel = WA_ALU; s.alu = 32'h11;
    s.wb_en = 1; s.wb_addr = 3; s.wb_data = 32'h22; applyStimulus(s); #2;
    checkValue("x3_bypass", rdata[31:0], 32'h11);
    s = idle(); s.rs0 = 3; applyStimulus(s); #2;
    checkValue("x3_data", rdata[31:0], 32'h11);
    checkValue("x3_busy", 32'(rbusy[0]), 32'h0);

    // Lock beats same-address clear; lock/clear to different addresses nets out.
    s = idle(); s.lock_en = 1; s.lock_addr = 9; applyStimulus(s);
    s = idle(); s.lock_en = 1; s.lock_addr = 9; s.wb_en = 1; s.wb_addr = 9;
    s.wb_data = 32'h55; applyStimulus(s);
    s = idle(); s.rs0 = 9; applyStimulus(s); #2;
    checkValue("x9_busy", 32'(rbusy[0]), 32'h1);
    checkValue("x9_cnt", 32'(busy_cnt), 32'h1);
    s = idle(); s.lock_en = 1; s.lock_addr = 6; applyStimulus(s);
    s = idle(); s.lock_en = 1; s.lock_addr = 4; s.wb_en = 1; s.wb_addr = 6;
    s.wb_data = 32'h66; applyStimulus(s); #2;
    checkValue("x4x6_cnt_before", 32'(busy_cnt), 32'h2);
    s = idle(); s.rs0 = 4; s.rs1 = 6; applyStimulus(s); #2;
    checkValue("x4_busy", 32'(rbusy[0]), 32'h1);
    checkValue("x6_busy", 32'(rbusy[1]), 32'h0);
    checkValue("x4x6_cnt", 32'(busy_cnt), 32'h2);

    // Reset mid-operation flushes busy state and storage.
    s = idle(); s.lock_en = 1; s.lock_addr = 2; applyStimulus(s);
    s = idle(); s.lock_en = 1; s.lock_addr = 8; applyStimulus(s);
    s = idle(); s.lock_en = 1; s.lock_addr = 10; applyStimulus(s);
    s = idle(); s.rst = 1; s.rs0 = 2; s.wa_en = 1; s.wa_addr = 2; s.wa_sel = WA_ALU;
    s.alu = 32'h77; applyStimulus(s); #2;
    checkValue("pre_rst_cnt", 32'(busy_cnt), 32'h5);
    s = idle(); s.rs0 = 2; s.rs1 = 8; applyStimulus(s); #2;
    checkValue("post_rst_x2", rdata[31:0], 32'h0);
    checkValue("post_rst_busy", 32'(rbusy), 32'h0);
    checkValue("post_rst_cnt", 32'(busy_cnt), 32'h0);

    // Randomised traffic, addresses folded to force collisions.
    for (int n = 0; n < 400; n++) begin
      s = idle();
      s.rs0       = AW'($urandom_range(0, 15));
      s.rs1       = AW'($urandom_range(0, 15));
      s.wa_en     = 1'($urandom_range(0, 1));
      s.wa_addr   = AW'($urandom_range(0, 15));
      s.wa_sel    = 2'($urandom_range(0, 3));
      s.alu       = $urandom;
      s.link      = $urandom;
      s.upper     = $urandom;
      s.wb_en     = ($urandom_range(0, 2) == 0);
      s.wb_addr   = AW'($urandom_range(0, 15));
      s.wb_data   = $urandom;
      s.lock_en   = ($urandom_range(0, 2) == 0);
      s.lock_addr = AW'($urandom_range(0, 15));
      s.rst       = ($urandom_range(0, 63) == 0);
      applyStimulus(s);
    end

    s = idle(); applyStimulus(s);
    repeat (3) @(negedge clk);
    #5;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
